// File: rtl/binconv_stream_engine.sv
// Streams N_OUT signed weighted sums of a binary pixel window, one channel per handshake.
// Define BINCONV_SATURATE_EN to clamp (instead of wrap) sums that exceed a narrow ACC_WIDTH.
module binconv_stream_engine #(
    parameter int N_IN      = 9,
    parameter int N_OUT     = 9,
    parameter int W_WIDTH   = 8,
    parameter int ACC_WIDTH = 20,
    localparam int ROW_W    = (N_OUT > 1) ? $clog2(N_OUT) : 1,
    localparam int COL_W    = (N_IN > 1) ? $clog2(N_IN) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        w_we,
    input  logic [ROW_W-1:0]            w_row,
    input  logic [COL_W-1:0]            w_col,
    input  logic signed [W_WIDTH-1:0]   w_data,
    output logic                        w_drop,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [N_IN-1:0]             in_x,
    input  logic                        in_mode,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [ACC_WIDTH-1:0] out_data,
    output logic [ROW_W-1:0]            out_idx,
    output logic                        out_last,
    output logic                        busy
);

    localparam int IW = W_WIDTH + $clog2(N_IN) + 1;
    localparam logic [ROW_W-1:0] LAST = ROW_W'(N_OUT - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t state_q, state_d;

    logic [ROW_W-1:0]            ch_q, ch_d, sel_ch;
    logic [N_IN-1:0]             x_q, x_d, sel_x;
    logic                        mode_q, mode_d, sel_mode;
    logic signed [ACC_WIDTH-1:0] data_q, data_d, red;
    logic                        load;
    logic                        wr_en;
    logic                        w_in_range;
    logic                        w_drop_q, w_drop_d;
    logic signed [W_WIDTH-1:0]   w_q [N_OUT][N_IN];
    logic signed [IW-1:0]        sum;
    logic signed [IW-1:0]        wext;

    // Frame sequencing; the result for the next channel is computed
    // combinationally and captured on the same edge that advances ch.
    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        x_d      = x_q;
        mode_d   = mode_q;
        load     = 1'b0;
        sel_ch   = ch_q;
        sel_x    = x_q;
        sel_mode = mode_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d  = RUN;
                    ch_d     = '0;
                    x_d      = in_x;
                    mode_d   = in_mode;
                    sel_ch   = '0;
                    sel_x    = in_x;
                    sel_mode = in_mode;
                    load     = 1'b1;
                end
            end
            RUN: begin
                if (out_ready) begin
                    if (ch_q == LAST) begin
                        state_d = IDLE;
                    end else begin
                        ch_d   = ch_q + 1'b1;
                        sel_ch = ch_q + 1'b1;
                        load   = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sum  = '0;
        wext = '0;
        for (int c = 0; c < N_IN; c++) begin
            wext = IW'(w_q[sel_ch][c]);
            if (sel_x[c]) begin
                sum = sum + wext;
            end else if (sel_mode) begin
                sum = sum - wext;
            end
        end
    end

    generate
        if (ACC_WIDTH >= IW) begin : g_ext
            assign red = ACC_WIDTH'(sum);
        end else begin : g_narrow
`ifdef BINCONV_SATURATE_EN
            localparam logic signed [IW-1:0] HI =
                {{(IW - ACC_WIDTH + 1){1'b0}}, {(ACC_WIDTH - 1){1'b1}}};
            localparam logic signed [IW-1:0] LO =
                {{(IW - ACC_WIDTH + 1){1'b1}}, {(ACC_WIDTH - 1){1'b0}}};
            always_comb begin
                if (sum > HI) begin
                    red = {1'b0, {(ACC_WIDTH - 1){1'b1}}};
                end else if (sum < LO) begin
                    red = {1'b1, {(ACC_WIDTH - 1){1'b0}}};
                end else begin
                    red = sum[ACC_WIDTH-1:0];
                end
            end
`else
            assign red = sum[ACC_WIDTH-1:0];
`endif
        end
    endgenerate

    assign data_d = load ? red : data_q;

    // Weight port only writes while idle and no window is being accepted.
    assign w_in_range = (int'(w_row) < N_OUT) && (int'(w_col) < N_IN);

    always_comb begin
        wr_en    = 1'b0;
        w_drop_d = 1'b0;
        if (w_we) begin
            if (state_q == IDLE && !in_valid && w_in_range) begin
                wr_en = 1'b1;
            end else begin
                w_drop_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ch_q     <= '0;
            x_q      <= '0;
            mode_q   <= 1'b0;
            data_q   <= '0;
            w_drop_q <= 1'b0;
            for (int r = 0; r < N_OUT; r++) begin
                for (int c = 0; c < N_IN; c++) begin
                    w_q[r][c] <= '0;
                end
            end
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            x_q      <= x_d;
            mode_q   <= mode_d;
            data_q   <= data_d;
            w_drop_q <= w_drop_d;
            if (wr_en) begin
                w_q[w_row][w_col] <= w_data;
            end
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == RUN);
    assign busy      = (state_q == RUN);
    assign out_data  = data_q;
    assign out_idx   = ch_q;
    assign out_last  = (state_q == RUN) && (ch_q == LAST);
    assign w_drop    = w_drop_q;

endmodule

// File: tb/tb_binconv_stream_engine.sv
// Bench for binconv_stream_engine: table vectors, hand sequences, random frames vs model.
// A second ACC_WIDTH=8 instance covers the narrow-output wrap/clamp path.
module tb_binconv_stream_engine;

    typedef int exp_t [9];

    typedef struct {
        logic [8:0] x;
        bit         mode;
        int         sidx;
        int         sn;
        bit         hold;
        exp_t       e;
    } vec_t;

`ifdef BINCONV_SATURATE_EN
    localparam int NARROW_EXP = 127;
`else
    localparam int NARROW_EXP = 119;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              w_we;
    logic [3:0]        w_row;
    logic [3:0]        w_col;
    logic [7:0]        w_data;
    logic              in_valid;
    logic [8:0]        in_x;
    logic              in_mode;
    logic              out_ready;

    logic              w_drop, in_ready, out_valid, out_last, busy;
    logic [19:0]       out_data;
    logic [3:0]        out_idx;

    logic              w_drop2, in_ready2, out_valid2, out_last2, busy2;
    logic [7:0]        out_data2;
    logic [3:0]        out_idx2;

    int passed = 0;
    int total  = 0;
    int wm [9][9];
    vec_t tbl [3];

    always #5 clk = ~clk;

    binconv_stream_engine dut (
        .clk(clk), .rst(rst),
        .w_we(w_we), .w_row(w_row), .w_col(w_col), .w_data(w_data),
        .w_drop(w_drop),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_idx(out_idx),
        .out_last(out_last), .busy(busy)
    );

    binconv_stream_engine #(.ACC_WIDTH(8)) dut8 (
        .clk(clk), .rst(rst),
        .w_we(w_we), .w_row(w_row), .w_col(w_col), .w_data(w_data),
        .w_drop(w_drop2),
        .in_valid(in_valid), .in_ready(in_ready2),
        .in_x(in_x), .in_mode(in_mode),
        .out_valid(out_valid2), .out_ready(out_ready),
        .out_data(out_data2), .out_idx(out_idx2),
        .out_last(out_last2), .busy(busy2)
    );

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_frame(input logic [8:0] x, input bit mode,
                               output exp_t e);
        for (int ch = 0; ch < 9; ch++) begin
            int s;
            s = 0;
            for (int c = 0; c < 9; c++) begin
                if (x[c]) s += wm[ch][c];
                else if (mode) s -= wm[ch][c];
            end
            e[ch] = s;
        end
    endtask

    task automatic write_w(input int r, input int c, input logic [7:0] v,
                           input bit exp_drop);
        w_row  = 4'(r);
        w_col  = 4'(c);
        w_data = v;
        w_we   = 1'b1;
        @(negedge clk);
        w_we = 1'b0;
        check("w_drop", int'(w_drop), int'(exp_drop));
        if (!exp_drop) wm[r][c] = int'($signed(v));
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        while (out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("drain_done", int'(out_valid), 0);
    endtask

    task automatic run_frame(input logic [8:0] x, input bit mode,
                             input exp_t e, input int sidx,
                             input int sn, input bit hold);
        int k, vcnt, stalls, cyc;
        bit rdy;
        k = 0; vcnt = 0; stalls = sn; cyc = 0;
        check("ready_idle", int'(in_ready), 1);
        in_valid  = 1'b1;
        in_x      = x;
        in_mode   = mode;
        out_ready = 1'b1;
        @(negedge clk);
        check("first_valid", int'(out_valid), 1);
        if (hold) in_x = ~x;
        else in_valid = 1'b0;
        while (k < 9 && cyc < 100) begin
            if (out_valid) vcnt++;
            rdy = !(k == sidx && stalls > 0);
            if (!rdy) stalls--;
            out_ready = rdy;
            check("valid", int'(out_valid), 1);
            check("data", int'($signed(out_data)), e[k]);
            check("idx", int'(out_idx), k);
            check("last", int'(out_last), int'(k == 8));
            if (rdy) k++;
            if (hold && k == 9) in_valid = 1'b0;
            @(negedge clk);
            cyc++;
        end
        check("frame_done", k, 9);
        check("end_valid", int'(out_valid), 0);
        check("end_ready", int'(in_ready), 1);
        check("end_busy", int'(busy), 0);
        if (sn > 0) check("valid_cycles", vcnt, 9 + sn);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        exp_t e;
        logic [8:0] rx;
        bit rm;
        int k;

        tbl[0] = '{x: 9'h155, mode: 1'b0, sidx: -1, sn: 0, hold: 1'b0,
                   e: '{1, -5, 1, -5, 1, -5, 1, -5, 1}};
        tbl[1] = '{x: 9'h155, mode: 1'b1, sidx: -1, sn: 0, hold: 1'b0,
                   e: '{5, -7, 5, -7, 5, -7, 5, -7, 5}};
        tbl[2] = '{x: 9'h155, mode: 1'b0, sidx: 2, sn: 3, hold: 1'b1,
                   e: '{1, -5, 1, -5, 1, -5, 1, -5, 1}};

        rst = 1'b1; w_we = 1'b0; w_row = '0; w_col = '0; w_data = '0;
        in_valid = 1'b0; in_x = '0; in_mode = 1'b0; out_ready = 1'b0;
        for (int r = 0; r < 9; r++)
            for (int c = 0; c < 9; c++) wm[r][c] = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_valid", int'(out_valid), 0);
        check("rst_ready", int'(in_ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_data", int'(out_data), 0);
        check("rst_idx", int'(out_idx), 0);
        check("rst_last", int'(out_last), 0);
        check("rst_drop", int'(w_drop), 0);

        for (int r = 0; r < 9; r++)
            for (int c = 0; c < 9; c++)
                write_w(r, c, (c == r) ? 8'd5 : 8'hFF, 1'b0);

        for (int i = 0; i < 3; i++)
            run_frame(tbl[i].x, tbl[i].mode, tbl[i].e,
                      tbl[i].sidx, tbl[i].sn, tbl[i].hold);

        // Write attempted while a frame is running must be dropped.
        in_valid = 1'b1; in_x = 9'h155; in_mode = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        w_row = 4'd0; w_col = 4'd0; w_data = 8'd9; w_we = 1'b1;
        @(negedge clk);
        w_we = 1'b0;
        check("drop_run", int'(w_drop), 1);
        @(negedge clk);
        check("drop_pulse", int'(w_drop), 0);
        check("stall_idx", int'(out_idx), 0);
        check("stall_data", int'($signed(out_data)), 1);
        drain();
        @(negedge clk);
        run_frame(tbl[0].x, tbl[0].mode, tbl[0].e, -1, 0, 1'b0);

        write_w(0, 0, 8'd9, 1'b0);
        write_w(9, 0, 8'd3, 1'b1);
        write_w(0, 9, 8'd3, 1'b1);
        model_frame(9'h155, 1'b0, e);
        check("model_ch0", e[0], 5);
        run_frame(9'h155, 1'b0, e, -1, 0, 1'b0);

        // Write coinciding with an input handshake is dropped.
        in_valid = 1'b1; in_x = 9'h0; in_mode = 1'b0; out_ready = 1'b1;
        w_row = 4'd1; w_col = 4'd1; w_data = 8'd77; w_we = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; w_we = 1'b0;
        check("drop_hs", int'(w_drop), 1);
        drain();

        for (int f = 0; f < 5; f++) begin
            for (int j = 0; j < 8; j++)
                write_w($urandom_range(0, 8), $urandom_range(0, 8),
                        8'($urandom), 1'b0);
            rx = 9'($urandom);
            rm = 1'($urandom);
            model_frame(rx, rm, e);
            run_frame(rx, rm, e, $urandom_range(0, 8),
                      $urandom_range(0, 2), 1'b0);
        end

        // Reset in the middle of a frame clears weights and aborts.
        in_valid = 1'b1; in_x = 9'h1FF; in_mode = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        k = 0;
        while (out_idx != 4'd4 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("reach_idx4", int'(out_idx), 4);
        rst = 1'b1;
        @(negedge clk);
        check("abort_valid", int'(out_valid), 0);
        check("abort_ready", int'(in_ready), 1);
        check("abort_busy", int'(busy), 0);
        rst = 1'b0;
        for (int r = 0; r < 9; r++)
            for (int c = 0; c < 9; c++) wm[r][c] = 0;
        model_frame(9'h1FF, 1'b0, e);
        run_frame(9'h1FF, 1'b0, e, -1, 0, 1'b0);

        // Narrow-output instance: 9 * 127 = 1143 overflows 8 bits.
        for (int r = 0; r < 9; r++)
            for (int c = 0; c < 9; c++)
                write_w(r, c, 8'd127, 1'b0);
        in_valid = 1'b1; in_x = 9'h1FF; in_mode = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 9; i++) begin
            check("wide_data", int'($signed(out_data)), 1143);
            check("narrow_valid", int'(out_valid2), 1);
            check("narrow_data", int'($signed(out_data2)), NARROW_EXP);
            check("narrow_idx", int'(out_idx2), i);
            @(negedge clk);
        end
        check("narrow_end", int'(out_valid2), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
